tdm_demux4: RTL and testbench
=============================

// Module: tdm_demux4
// PURPOSE
//   Receive end of the 4:1 select path: accepts a time-division-multiplexed stream
//   (slots a,b,c,d in rotation, slot 0 flagged by din_sync) and distributes each
//   slot to its own registered output channel. Slot counter drives s1/s0 with the
//   same select encoding the 4:1 mux uses. Sits between the serial link and per-channel logic.
// PARAMETERS
//   WIDTH    1   bits per slot / per output channel
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-high reset
//   din        in   WIDTH  slot data
//   din_valid  in   1      din/din_sync qualify this cycle
//   din_sync   in   1      with din_valid: this beat is slot 0 (channel a)
//   a,b,c,d    out  WIDTH  registered channel outputs (slot 0..3)
//   s1,s0      out  1      select of the slot expected next ({s1,s0}=0->a..3->d)
//   ch_valid   out  4      per-channel one-cycle update strobe, bit0=a .. bit3=d
//   frame_done out  1      one-cycle pulse when slot 3 (d) is captured
//   locked     out  1      high while in RUN state
//   sync_err   out  1      sticky: din_sync seen at slot != 0 while locked
// BEHAVIOUR
//   Reset (async, rst=1): a,b,c,d=0; {s1,s0}=0; ch_valid=0; frame_done=0; locked=0;
//     sync_err=0; state=HUNT. Reset mid-frame discards partial frame.
//   States: HUNT (wait for sync), RUN (locked).
//   HUNT: beats with din_valid=1, din_sync=0 ignored. din_valid=1 & din_sync=1 ->
//     capture slot 0 into a, {s1,s0}<=1, state<=RUN, locked<=1 next edge.
//   RUN: each din_valid beat captures din into channel {s1,s0}, {s1,s0} increments
//     mod 4 (3 wraps to 0). din_valid=0: nothing changes (stall holds state).
//   Latency: din captured on edge where din_valid=1; output + ch_valid visible
//     the following cycle (1 clk). ch_valid bit and frame_done high exactly 1 cycle.
//   frame_done: asserted with the capture of slot 3.
//   Sync while RUN and {s1,s0}==0: normal, treated as slot 0.
//   Sync while RUN and {s1,s0}!=0: realign - beat captured as slot 0 into a,
//     {s1,s0}<=1, sync_err<=1 (sticky until rst); partial frame not flagged done.
//   Sync absent at slot 0 while RUN: accepted (free-run), no error.
//   Outputs hold last captured value until overwritten; no combinational din->out path.
// CONFIGURATION
//   FRAME_HOLD_EN defined: slots captured into shadow regs; a,b,c,d update together
//     on the cycle after slot 3 capture, ch_valid=4'b1111 for that one cycle with
//     frame_done. Realign discards shadow contents; outputs keep previous frame.
//   FRAME_HOLD_EN undefined: each channel updates individually as its slot is
//     captured, ch_valid one-hot per beat (default).
// TESTING
//   rst pulse mid-frame -> all outputs 0, locked=0, next non-sync beats ignored.
//   HUNT, beats (sync=1,din=1),(0),(1),(1) back-to-back -> a=1,b=0,c=1,d=1;
//     ch_valid 0001,0010,0100,1000 on consecutive cycles; frame_done with d.
//   Same frame with din_valid=0 gaps of 3 cycles between beats -> identical
//     outputs, {s1,s0} holds during gaps.
//   Locked at {s1,s0}=2, beat sync=1 din=1 -> a=1, {s1,s0}=1, sync_err=1 sticky,
//     no frame_done.
//   Two frames without sync after first -> wrap 3->0, second frame captured, no error.
//   FRAME_HOLD_EN: frame 1,0,0,0 then 1,1,0,1 -> a..d unchanged until slot 3,
//     then 1,1,0,1 at once with ch_valid=1111.

Source files
------------

// File: rtl/tdm_demux4.sv
// tdm_demux4: TDM receive demultiplexer. It hunts for slot-0 sync, then steers slots a..d into registered channels.
// Latency: 1 clk from the din_valid beat to the channel output, ch_valid and frame_done.
// Backpressure: none. A din_valid=0 cycle is a stall that holds every piece of state.
// Optional feature: define FRAME_HOLD_EN to publish a..d together after slot 3. Otherwise each channel updates per slot.
module tdm_demux4 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             din_sync,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             s1,
  output logic             s0,
  output logic [3:0]       ch_valid,
  output logic             frame_done,
  output logic             locked,
  output logic             sync_err
);

  typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_sel;
  logic             r_err;
  logic [WIDTH-1:0] r_a, r_b, r_c, r_d;
  logic [3:0]       r_chv;
  logic             r_fd;
  logic             w_beat;
  logic             w_realign;
  logic [1:0]       w_slot;

  // State register: HUNT until the first sync beat, then RUN until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= HUNT;
    else     r_state <= w_state_nxt;
  end

  // Next state: only a valid sync beat leaves HUNT, and nothing leaves RUN.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == HUNT && din_valid && din_sync) w_state_nxt = RUN;
  end

  // Beat decode: a sync beat always forces slot 0. A sync beat at a nonzero slot in RUN is a realign.
  always_comb begin
    w_beat    = 1'b0;
    w_slot    = r_sel;
    w_realign = 1'b0;
    if (din_valid) begin
      if (din_sync) begin
        w_beat    = 1'b1;
        w_slot    = 2'd0;
        w_realign = (r_state == RUN) && (r_sel != 2'd0);
      end else if (r_state == RUN) begin
        w_beat = 1'b1;
      end
    end
  end

  // Slot counter: it points at the slot expected next. It only advances on captured beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_sel <= 2'd0;
    else if (w_beat) r_sel <= w_slot + 2'd1;
  end

  // Sticky misaligned-sync flag: only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_err <= 1'b0;
    else if (w_realign) r_err <= 1'b1;
  end

`ifdef FRAME_HOLD_EN
  logic [WIDTH-1:0] r_sh_a, r_sh_b, r_sh_c;

  // Shadow capture of slots 0..2. A realign overwrites slot 0, and slots 1..2 are rewritten before the next publish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_a <= '0;
      r_sh_b <= '0;
      r_sh_c <= '0;
    end else if (w_beat) begin
      case (w_slot)
        2'd0:    r_sh_a <= din;
        2'd1:    r_sh_b <= din;
        2'd2:    r_sh_c <= din;
        default: ;
      endcase
    end
  end

  // Frame publish: on the slot 3 beat, all four channels load at once. Slot 3 is taken straight from din.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_c   <= '0;
      r_d   <= '0;
      r_chv <= 4'b0000;
      r_fd  <= 1'b0;
    end else begin
      r_chv <= 4'b0000;
      r_fd  <= 1'b0;
      if (w_beat && w_slot == 2'd3) begin
        r_a   <= r_sh_a;
        r_b   <= r_sh_b;
        r_c   <= r_sh_c;
        r_d   <= din;
        r_chv <= 4'b1111;
        r_fd  <= 1'b1;
      end
    end
  end
`else
  // Per-slot capture: the addressed channel loads din, and its strobe pulses for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_c   <= '0;
      r_d   <= '0;
      r_chv <= 4'b0000;
      r_fd  <= 1'b0;
    end else begin
      r_chv <= 4'b0000;
      r_fd  <= 1'b0;
      if (w_beat) begin
        r_chv <= 4'b0001 << w_slot;
        r_fd  <= (w_slot == 2'd3);
        case (w_slot)
          2'd0:    r_a <= din;
          2'd1:    r_b <= din;
          2'd2:    r_c <= din;
          default: r_d <= din;
        endcase
      end
    end
  end
`endif

  // Output decode: every output comes from a register, so there is no combinational path from din.
  always_comb begin
    a          = r_a;
    b          = r_b;
    c          = r_c;
    d          = r_d;
    s1         = r_sel[1];
    s0         = r_sel[0];
    ch_valid   = r_chv;
    frame_done = r_fd;
    locked     = (r_state == RUN);
    sync_err   = r_err;
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// Testbench for tdm_demux4: directed scenarios with literal expectations, then randomized beats.
// Every cycle is compared against a slot-level reference model.
// Build with FRAME_HOLD_EN defined to exercise frame-hold mode.
module tb_tdm_demux4;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         din_sync = 1'b0;
  logic [W-1:0] a, b, c, d;
  logic         s1, s0, frame_done, locked, sync_err;
  logic [3:0]   ch_valid;

  int n_tests = 0;
  int n_fail  = 0;

  tdm_demux4 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_sync(din_sync),
    .a(a), .b(b), .c(c), .d(d), .s1(s1), .s0(s0), .ch_valid(ch_valid),
    .frame_done(frame_done), .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  // Reference model: it tracks the lock state, the next expected slot and the channel contents.
  int           m_nxt = 0;
  bit           m_lock = 0, m_err = 0, m_fd = 0;
  logic [3:0]   m_chv = 4'b0;
  logic [W-1:0] m_out[4] = '{default: '0};
  logic [W-1:0] m_sh[4]  = '{default: '0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_nxt = 0; m_lock = 0; m_err = 0; m_fd = 0; m_chv = 4'b0;
      for (int i = 0; i < 4; i++) begin m_out[i] = '0; m_sh[i] = '0; end
    end else begin
      int slot;
      slot = -1;
      m_chv = 4'b0;
      m_fd = 0;
      if (din_valid) begin
        if (din_sync) begin
          if (m_lock && m_nxt != 0) m_err = 1;
          slot = 0;
        end else if (m_lock) begin
          slot = m_nxt;
        end
      end
      if (slot >= 0) begin
        m_lock = 1;
        m_nxt = (slot + 1) % 4;
`ifdef FRAME_HOLD_EN
        m_sh[slot] = din;
        if (slot == 3) begin
          for (int i = 0; i < 4; i++) m_out[i] = m_sh[i];
          m_chv = 4'b1111;
          m_fd = 1;
        end
`else
        m_out[slot] = din;
        m_chv = 4'(1 << slot);
        m_fd = (slot == 3);
`endif
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("a", 32'(a), 32'(m_out[0]));
    chk("b", 32'(b), 32'(m_out[1]));
    chk("c", 32'(c), 32'(m_out[2]));
    chk("d", 32'(d), 32'(m_out[3]));
    chk("sel", {30'b0, s1, s0}, 32'(m_nxt));
    chk("ch_valid", {28'b0, ch_valid}, {28'b0, m_chv});
    chk("frame_done", {31'b0, frame_done}, {31'b0, m_fd});
    chk("locked", {31'b0, locked}, {31'b0, m_lock});
    chk("sync_err", {31'b0, sync_err}, {31'b0, m_err});
  endtask

  // At each falling edge, check the outputs from the previous beat, then drive the next beat.
  task automatic step(input logic v, input logic s, input logic [W-1:0] dd);
    @(negedge clk);
    compare();
    din_valid = v;
    din_sync  = s;
    din       = dd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    compare();
    rst = 1'b1;
    din_valid = 1'b0;
    din_sync = 1'b0;
    @(negedge clk);
    compare();
    chk("rst_a", 32'(a), 0); chk("rst_b", 32'(b), 0);
    chk("rst_c", 32'(c), 0); chk("rst_d", 32'(d), 0);
    chk("rst_locked", {31'b0, locked}, 0);
    chk("rst_sel", {30'b0, s1, s0}, 0);
    chk("rst_err", {31'b0, sync_err}, 0);
    chk("rst_chv", {28'b0, ch_valid}, 0);
    rst = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    compare();
    chk("init_locked", {31'b0, locked}, 0);
    chk("init_a", 32'(a), 0);
    rst = 1'b0;

    // In HUNT, a non-sync beat is ignored.
    step(1, 0, 4'h5);
    step(0, 0, 0);
    chk("hunt_ignore_locked", {31'b0, locked}, 0);
    chk("hunt_ignore_chv", {28'b0, ch_valid}, 0);

`ifdef FRAME_HOLD_EN
    // Frame 1,0,0,0 followed by frame 1,1,0,1.
    step(1, 1, 1); step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
    step(1, 1, 1);
    chk("h_f1_a", 32'(a), 1); chk("h_f1_b", 32'(b), 0); chk("h_f1_d", 32'(d), 0);
    chk("h_f1_chv", {28'b0, ch_valid}, 32'hF);
    chk("h_f1_fd", {31'b0, frame_done}, 1);
    step(1, 0, 1);
    chk("h_hold_chv", {28'b0, ch_valid}, 0);
    step(1, 0, 0);
    chk("h_hold_b", 32'(b), 0);
    step(1, 0, 1);
    chk("h_hold_d", 32'(d), 0);
    step(0, 0, 0);
    chk("h_f2_a", 32'(a), 1); chk("h_f2_b", 32'(b), 1);
    chk("h_f2_c", 32'(c), 0); chk("h_f2_d", 32'(d), 1);
    chk("h_f2_chv", {28'b0, ch_valid}, 32'hF);
`else
    // Back-to-back frame 1,0,1,1.
    step(1, 1, 1); step(1, 0, 0);
    chk("f_chv0", {28'b0, ch_valid}, 1); chk("f_a", 32'(a), 1);
    chk("f_locked", {31'b0, locked}, 1); chk("f_sel1", {30'b0, s1, s0}, 1);
    step(1, 0, 1);
    chk("f_chv1", {28'b0, ch_valid}, 2); chk("f_b", 32'(b), 0);
    chk("f_sel2", {30'b0, s1, s0}, 2);
    step(1, 0, 1);
    chk("f_chv2", {28'b0, ch_valid}, 4); chk("f_c", 32'(c), 1);
    step(0, 0, 0);
    chk("f_chv3", {28'b0, ch_valid}, 8); chk("f_d", 32'(d), 1);
    chk("f_fd", {31'b0, frame_done}, 1); chk("f_sel_wrap", {30'b0, s1, s0}, 0);
    step(0, 0, 0);
    chk("f_chv_off", {28'b0, ch_valid}, 0);
    chk("f_fd_off", {31'b0, frame_done}, 0);
`endif

    // Realign: a sync beat arrives while the next expected slot is 2.
    step(1, 1, 0); step(1, 0, 1); step(1, 1, 1);
    chk("ra_err_before", {31'b0, sync_err}, 0);
    chk("ra_sel_before", {30'b0, s1, s0}, 2);
    step(0, 0, 0);
    chk("ra_err", {31'b0, sync_err}, 1);
    chk("ra_sel", {30'b0, s1, s0}, 1);
    chk("ra_fd", {31'b0, frame_done}, 0);
`ifndef FRAME_HOLD_EN
    chk("ra_a", 32'(a), 1);
`endif
    step(0, 0, 0);
    chk("ra_sticky", {31'b0, sync_err}, 1);

    // Reset in mid-frame. After it, non-sync beats are ignored.
    step(1, 1, 1); step(1, 0, 1);
    do_reset();
    step(1, 0, 3); step(1, 0, 2);
    chk("post_rst_locked", {31'b0, locked}, 0);
    chk("post_rst_chv", {28'b0, ch_valid}, 0);

    // A frame with 3-cycle gaps between beats. The select must hold during the gaps.
    step(1, 1, 1);
    repeat (3) step(0, 0, 0);
    chk("gap_sel_hold", {30'b0, s1, s0}, 1);
    step(1, 0, 0); repeat (3) step(0, 0, 0);
    chk("gap_sel_hold2", {30'b0, s1, s0}, 2);
    step(1, 0, 1); repeat (3) step(0, 0, 0);
    step(1, 0, 1); step(0, 0, 0);
    chk("gap_fd", {31'b0, frame_done}, 1);
    chk("gap_a", 32'(a), 1); chk("gap_b", 32'(b), 0);
    chk("gap_c", 32'(c), 1); chk("gap_d", 32'(d), 1);

    // Randomized traffic: free-running frames with mostly-correct sync, stalls, and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        logic v, s;
        v = ($urandom_range(0, 9) < 6);
        if (!m_lock)          s = ($urandom_range(0, 9) < 3);
        else if (m_nxt == 0)  s = ($urandom_range(0, 9) < 5);
        else                  s = ($urandom_range(0, 29) == 0);
        step(v, s, W'($urandom));
      end
    end
    step(0, 0, 0);
    step(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
